// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the LFSR random-word scheduler.
// Pure declarations; no logic.
package lfsr_rng_pkg;

   typedef enum logic [1:0] {
      WARM = 2'd0,
      IDLE = 2'd1,
      STIR = 2'd2
   } state_e;

   localparam int              LFSR_W      = 32;
   localparam logic [LFSR_W-1:0] LOCKUP_WORD = 32'hFFFF_FFFF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lfsr_rng_scheduler_if.sv
// Consumer and LFSR-side signals of the scheduler; slave = scheduler, master = its environment.
// Grants are single-cycle pulses; requests are levels held until granted.
interface lfsr_rng_scheduler_if
   import lfsr_rng_pkg::*;
#(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic              reseed;
   logic [LFSR_W-1:0] lfsr_seq;
   logic [NREQ-1:0]   gnt;
   logic [LFSR_W-1:0] data;
   logic              busy;
   logic              lfsr_reset;
   logic              lfsr_enable;

   modport slave (
      input  req, reseed, lfsr_seq,
      output gnt, data, busy, lfsr_reset, lfsr_enable
   );

   modport master (
      output req, reseed, lfsr_seq,
      input  gnt, data, busy, lfsr_reset, lfsr_enable
   );
endinterface

// File: rtl/lfsr_rng_scheduler_rr_arbiter.sv
// Round-robin pick among NREQ requesters, searching from rr_ptr_i+1 with wrap.
// Purely combinational; vld_o low when nothing is requested.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);
   logic [IDX_W-1:0] k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      k     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = IDX_W'((32'(rr_ptr_i) + 32'(i)) % NREQ);
         if (!vld_o && req_i[k]) begin
            gnt_o[k] = 1'b1;
            idx_o    = k;
            vld_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/lfsr_rng_scheduler.sv
// Shares one 32-bit LFSR among NREQ requesters: warm-up, round-robin word grants, STEP-shift stir.
// Optional XNOR all-ones lockup recovery with output lockup_err when LFSR_RNG_LOCKUP_CHECK_EN is defined.
module lfsr_rng_scheduler
   import lfsr_rng_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int STEP   = 32,
   parameter int WARMUP = 64
) (
   input  logic clock,
   input  logic reset,
`ifdef LFSR_RNG_LOCKUP_CHECK_EN
   output logic lockup_err,
`endif
   lfsr_rng_scheduler_if.slave sif
);
   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(max_int(STEP, WARMUP) + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [LFSR_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              reseed_q, reseed_d;
   logic              lockup;

   logic [NREQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_vld;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
      .req_i    (sif.req),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (arb_gnt),
      .idx_o    (arb_idx),
      .vld_o    (arb_vld)
   );

`ifdef LFSR_RNG_LOCKUP_CHECK_EN
   assign lockup     = !reset && (state_q != WARM) && (sif.lfsr_seq == LOCKUP_WORD);
   assign lockup_err = lockup;
`else
   assign lockup     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = '0;
      data_d   = data_q;
      rr_ptr_d = rr_ptr_q;
      reseed_d = 1'b0;
      // A lockup is recovered exactly like an external reseed.
      if (sif.reseed || lockup) begin
         state_d  = WARM;
         cnt_d    = '0;
         reseed_d = 1'b1;
      end else begin
         case (state_q)
            WARM: begin
               // Hold the count while the LFSR is in reset so warm-up is WARMUP real shifts.
               if (!reseed_q) begin
                  if (cnt_q == CNT_W'(WARMUP - 1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            IDLE: begin
               if (arb_vld) begin
                  gnt_d    = arb_gnt;
                  data_d   = sif.lfsr_seq;
                  rr_ptr_d = arb_idx;
                  state_d  = STIR;
                  cnt_d    = '0;
               end
            end
            STIR: begin
               if (cnt_q == CNT_W'(STEP - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = WARM;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= WARM;
         cnt_q    <= '0;
         gnt_q    <= '0;
         data_q   <= '0;
         rr_ptr_q <= IDX_W'(NREQ - 1);
         reseed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         data_q   <= data_d;
         rr_ptr_q <= rr_ptr_d;
         reseed_q <= reseed_d;
      end
   end

   assign sif.gnt         = gnt_q;
   assign sif.data        = data_q;
   assign sif.busy        = (state_q == WARM) || (state_q == STIR);
   assign sif.lfsr_enable = (state_q == WARM) || (state_q == STIR);
   assign sif.lfsr_reset  = reset | reseed_q;

endmodule

// File: tb/tb_lfsr_rng_scheduler.sv
// Bench for lfsr_rng_scheduler: hosts a 32-bit XNOR LFSR and scoreboards every grant.
// Expected grants are queued as stimulus is applied and checked when gnt pulses.
module tb_lfsr_rng_scheduler;
   localparam int NREQ   = 4;
   localparam int STEP   = 32;
   localparam int WARMUP = 64;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic [31:0]     data;
      int              gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        force_ones;
   logic [31:0] lfsr_q;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   int          gnt2_cnt = 0;
   bit          mon_en = 1'b0;
   exp_t        exp_q[$];
   exp_t        e;
   int          wn, wbad;

   lfsr_rng_scheduler_if #(.NREQ(NREQ)) sif ();

`ifdef LFSR_RNG_LOCKUP_CHECK_EN
   logic lockup_err;
`endif

   lfsr_rng_scheduler #(.NREQ(NREQ), .STEP(STEP), .WARMUP(WARMUP)) dut (
      .clock      (clk),
      .reset      (rst),
`ifdef LFSR_RNG_LOCKUP_CHECK_EN
      .lockup_err (lockup_err),
`endif
      .sif        (sif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
   endfunction

   function automatic logic [31:0] lfsr_adv(input int n);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < n; i++) s = lfsr_step(s);
      return s;
   endfunction

   // The LFSR instance the scheduler drives.
   always @(posedge clk) begin
      if (sif.lfsr_reset)       lfsr_q <= '0;
      else if (sif.lfsr_enable) lfsr_q <= lfsr_step(lfsr_q);
   end
   assign sif.lfsr_seq = force_ones ? 32'hFFFF_FFFF : lfsr_q;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push(input logic [NREQ-1:0] g, input logic [31:0] d, input int gap);
      exp_t x;
      x.gnt = g; x.data = d; x.gap = gap;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (mon_en && sif.gnt != '0) begin
         if (sif.gnt[2]) gnt2_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_gnt", 64'(sif.gnt), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("gnt", 64'(sif.gnt), 64'(e.gnt));
            chk("data", 64'(sif.data), 64'(e.data));
            if (e.gap != 0) chk("gnt_gap", 64'(cyc - last_cyc), 64'(e.gap));
         end
         last_cyc = cyc;
      end
   end

   task automatic do_reset();
      rst = 1'b1; sif.req = '0; sif.reseed = 1'b0; force_ones = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_warm(output int n, output int en_bad);
      bit done;
      n = 0; en_bad = 0; done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk); #1;
         if (!sif.busy) done = 1'b1;
         else begin
            n++;
            if (!sif.lfsr_enable) en_bad++;
         end
      end
      if (!done) chk("warm_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_q(input int n, input int limit);
      for (int i = 0; i < limit && exp_q.size() > n; i++) begin
         @(negedge clk); #1;
      end
      if (exp_q.size() > n) begin
         chk("queue_timeout", 64'(exp_q.size()), 64'(n));
         exp_q.delete();
      end
   endtask

   initial begin
      int order [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

      // Power-on reset and warm-up
      rst = 1'b1; sif.req = '0; sif.reseed = 1'b0; force_ones = 1'b0;
      #1;
      chk("lfsr_reset_in_reset", 64'(sif.lfsr_reset), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      wait_warm(wn, wbad);
      chk("warm_len", 64'(wn), 64'(WARMUP));
      chk("warm_enable", 64'(wbad), 64'd0);
      chk("idle_enable", 64'(sif.lfsr_enable), 64'd0);
      chk("idle_gnt", 64'(sif.gnt), 64'd0);
      chk("idle_data", 64'(sif.data), 64'd0);
      chk("idle_lfsr_reset", 64'(sif.lfsr_reset), 64'd0);

      // Single constant requester: one grant every STEP+1 cycles, STEP shifts apart
      sif.req = 4'b0001;
      for (int k = 0; k < 4; k++)
         push(4'b0001, lfsr_adv(WARMUP + STEP * k), (k == 0) ? 0 : STEP + 1);
      wait_q(0, 200);
      sif.req = '0;

      // Round-robin order, then a narrowed request set
      do_reset();
      wait_warm(wn, wbad);
      sif.req = 4'b1111;
      for (int k = 0; k < 8; k++)
         push(4'(1 << order[k]), lfsr_adv(WARMUP + STEP * k), (k == 0) ? 0 : STEP + 1);
      wait_q(2, 300);
      sif.req = 4'b1010;
      wait_q(0, 150);
      sif.req = '0;

      // Reseed ten cycles into a stir
      do_reset();
      wait_warm(wn, wbad);
      sif.req = 4'b0001;
      push(4'b0001, lfsr_adv(WARMUP), 0);
      wait_q(0, 10);
      repeat (10) @(negedge clk);
      #1;
      sif.reseed = 1'b1;
      push(4'b0001, lfsr_adv(WARMUP), 1 + 10 + 1 + WARMUP + 1);
      @(negedge clk); #1;
      sif.reseed = 1'b0;
      chk("reseed_lfsr_reset", 64'(sif.lfsr_reset), 64'd1);
      chk("reseed_gnt", 64'(sif.gnt), 64'd0);
      chk("reseed_busy", 64'(sif.busy), 64'd1);
      chk("reseed_data_hold", 64'(sif.data), 64'(lfsr_adv(WARMUP)));
      wait_q(0, 120);
      sif.req = '0;

      // Reseed and request in the same IDLE cycle
      do_reset();
      wait_warm(wn, wbad);
      sif.req = 4'b0001;
      sif.reseed = 1'b1;
      @(negedge clk); #1;
      sif.reseed = 1'b0;
      chk("reseed_wins_gnt", 64'(sif.gnt), 64'd0);
      chk("reseed_wins_lfsr_reset", 64'(sif.lfsr_reset), 64'd1);
      push(4'b0001, lfsr_adv(WARMUP), 0);
      wait_q(0, 120);
      sif.req = '0;

      // Request dropped during a stir is never served
      do_reset();
      wait_warm(wn, wbad);
      sif.req = 4'b0001;
      push(4'b0001, lfsr_adv(WARMUP), 0);
      wait_q(0, 10);
      gnt2_cnt = 0;
      sif.req = 4'b0100;
      repeat (5) begin @(negedge clk); #1; end
      sif.req = '0;
      repeat (80) @(negedge clk);
      #1;
      chk("dropped_req_gnt2", 64'(gnt2_cnt), 64'd0);

      // All-ones LFSR word
      do_reset();
      wait_warm(wn, wbad);
      force_ones = 1'b1;
      sif.req = 4'b0001;
`ifdef LFSR_RNG_LOCKUP_CHECK_EN
      #1;
      chk("lockup_err", 64'(lockup_err), 64'd1);
      @(negedge clk); #1;
      force_ones = 1'b0;
      chk("lockup_err_pulse", 64'(lockup_err), 64'd0);
      chk("lockup_lfsr_reset", 64'(sif.lfsr_reset), 64'd1);
      chk("lockup_no_gnt", 64'(sif.gnt), 64'd0);
      push(4'b0001, lfsr_adv(WARMUP), 0);
      wait_q(0, 120);
      sif.req = '0;
`else
      push(4'b0001, 32'hFFFF_FFFF, 0);
      @(negedge clk); #1;
      force_ones = 1'b0;
      sif.req = '0;
      wait_q(0, 5);
      chk("ones_data_held", 64'(sif.data), 64'hFFFF_FFFF);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end
endmodule
